// File: rtl/dc_blocker.sv
// First-order DC blocker y[n] = x[n] - x[n-1] + a*y[n-1], a = 1 - 2^-ALPHA_SHIFT,
// on offset-binary input samples with one register stage of latency.
module dc_blocker #(
    parameter int INPUT_DW           = 12,
    parameter int INTERNAL_FRAC_BITS = 8,
    parameter int OUTPUT_FRAC_BITS   = 4,
    parameter int ALPHA_SHIFT        = 5
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [INPUT_DW-1:0]                          data_i,
    input  logic                                         en_i,
    input  logic                                         valid_i,
    output logic                                         valid_o,
    output logic signed [INPUT_DW+OUTPUT_FRAC_BITS:0]    data_o
);

    localparam int YW = INPUT_DW + 2 + INTERNAL_FRAC_BITS;
    localparam int SW = YW + 2;
    localparam int OW = INPUT_DW + 1 + OUTPUT_FRAC_BITS;
    localparam int SH = INTERNAL_FRAC_BITS - OUTPUT_FRAC_BITS;

    localparam logic signed [SW-1:0] Y_MAX = {{(SW-YW+1){1'b0}}, {(YW-1){1'b1}}};
    localparam logic signed [SW-1:0] Y_MIN = {{(SW-YW+1){1'b1}}, {(YW-1){1'b0}}};
    localparam logic signed [YW:0]   O_MAX = {{(YW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [YW:0]   O_MIN = {{(YW-OW+2){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [YW:0]   RND   = (YW+1)'((2**SH) / 2);

    logic signed [INPUT_DW-1:0] xs;
    logic signed [INPUT_DW-1:0] x_prev_q, x_prev_d;
    logic signed [INPUT_DW:0]   diff;
    logic signed [SW-1:0]       d_ext, y_ext, sum;
    logic signed [YW-1:0]       y_prev_q, y_prev_d, y_sat;
    logic signed [YW:0]         y_rnd, y_shift;
    logic signed [OW-1:0]       data_q, data_d, out_sat, bypass;
    logic                       valid_q;

    // Inverting the MSB turns offset-binary into two's complement around mid-code.
    assign xs     = {~data_i[INPUT_DW-1], data_i[INPUT_DW-2:0]};
    assign diff   = (INPUT_DW+1)'(xs) - (INPUT_DW+1)'(x_prev_q);
    assign bypass = OW'(xs) <<< OUTPUT_FRAC_BITS;

    always_comb begin
        d_ext = SW'(diff) <<< INTERNAL_FRAC_BITS;
        y_ext = SW'(y_prev_q);
        sum   = d_ext + y_ext - (y_ext >>> ALPHA_SHIFT);

        if (sum > Y_MAX) begin
            y_sat = Y_MAX[YW-1:0];
        end else if (sum < Y_MIN) begin
            y_sat = Y_MIN[YW-1:0];
        end else begin
            y_sat = sum[YW-1:0];
        end

        y_rnd   = (YW+1)'(y_sat) + RND;
        y_shift = y_rnd >>> SH;

        if (y_shift > O_MAX) begin
            out_sat = O_MAX[OW-1:0];
        end else if (y_shift < O_MIN) begin
            out_sat = O_MIN[OW-1:0];
        end else begin
            out_sat = y_shift[OW-1:0];
        end
    end

    always_comb begin
        x_prev_d = x_prev_q;
        y_prev_d = y_prev_q;
        data_d   = data_q;
        if (valid_i) begin
            if (en_i) begin
                x_prev_d = xs;
                y_prev_d = y_sat;
                data_d   = out_sat;
            end else begin
                // Bypass restarts the filter so re-enabling begins from mid-code.
                x_prev_d = '0;
                y_prev_d = '0;
                data_d   = bypass;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
            data_q   <= data_d;
            valid_q  <= valid_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_dc_blocker.sv
// Directed bench for dc_blocker: an integer reference model fills a queue of
// expected outputs at each strobe; a monitor pops and compares on every valid_o.
`timescale 1ns/1ps
module tb_dc_blocker;

    logic               clk = 1'b0;
    logic               rst;
    logic [11:0]        data_i;
    logic               en_i;
    logic               valid_i;
    logic               valid_o;
    logic signed [16:0] data_o;

    int     total = 0;
    int     bad   = 0;
    longint exp_q[$];
    longint last_out = 0;
    bit     mon_on  = 1'b0;
    bit     stat_on = 1'b0;
    longint stat_sum = 0;
    longint stat_peak = 0;
    int     stat_cnt = 0;

    longint mx = 0;
    longint my = 0;

    dc_blocker #(
        .INPUT_DW           (12),
        .INTERNAL_FRAC_BITS (8),
        .OUTPUT_FRAC_BITS   (4),
        .ALPHA_SHIFT        (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .en_i    (en_i),
        .valid_i (valid_i),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint model_step(input int data, input bit en);
        longint xs, y;
        xs = longint'(data) - 2048;
        if (!en) begin
            mx = 0;
            my = 0;
            return xs * 16;
        end
        y  = (xs - mx) * 256 + my - floor_div(my, 32);
        y  = clamp(y, -(64'sd1 <<< 21), (64'sd1 <<< 21) - 1);
        mx = xs;
        my = y;
        return clamp(floor_div(y + 8, 16), -65536, 65535);
    endfunction

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            if (!rst) begin
                check("rst_valid_o", valid_o, 0);
                check("rst_data_o", data_o, 0);
                last_out = 0;
            end else if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_o_queue_size", exp_q.size(), 1);
                end else begin
                    check("data_o", data_o, exp_q.pop_front());
                end
                last_out = data_o;
                if (stat_on) begin
                    stat_sum += longint'(data_o);
                    if ((data_o < 0 ? -longint'(data_o) : longint'(data_o)) > stat_peak)
                        stat_peak = (data_o < 0) ? -longint'(data_o) : longint'(data_o);
                    stat_cnt++;
                end
            end else begin
                check("hold_data_o", data_o, last_out);
            end
        end
    end

    // Strobe one sample, then idle gap-1 cycles with random data/en that must be ignored.
    task automatic send(input int data, input bit en, input int gap, input bit use_c, input longint c);
        longint m;
        @(negedge clk);
        data_i  = 12'(data);
        en_i    = en;
        valid_i = 1'b1;
        m = model_step(data, en);
        exp_q.push_back(use_c ? c : m);
        for (int i = 1; i < gap; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            data_i  = 12'($urandom_range(0, 4095));
            en_i    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        valid_i = 1'b1;
        data_i  = 12'($urandom_range(0, 4095));
        en_i    = 1'b1;
        mx = 0;
        my = 0;
        @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
    endtask

    initial begin
        int s;
        rst     = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        en_i    = 1'b0;
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // Mid-code DC must produce exactly zero.
        for (int n = 0; n < 2048; n++) send(2048, 1'b1, 10, 1'b1, 0);

        // Step of +1000 codes: 16000, 15500, then model-checked decay.
        send(3048, 1'b1, 10, 1'b1, 16000);
        send(3048, 1'b1, 10, 1'b1, 15500);
        for (int n = 0; n < 40; n++) send(3048, 1'b1, 10, 1'b0, 0);

        // Bypass extremes, then re-enable starting from cleared state.
        send(4095, 1'b0, 3, 1'b1, 32752);
        send(0,    1'b0, 3, 1'b1, -32768);
        send(3048, 1'b1, 3, 1'b1, 16000);
        send(3048, 1'b1, 3, 1'b0, 0);
        idle(2);

        // Full-scale alternation, one sample per clock.
        do_reset();
        for (int n = 0; n < 16; n++) send((n % 2 == 0) ? 0 : 4095, 1'b1, 1, 1'b0, 0);
        idle(2);

        // 457 kHz tone at 10 MS/s; 766 samples is almost exactly 35 periods.
        do_reset();
        for (int n = 0; n < 971; n++) begin
            s = 2048 + int'(1000.0 * $cos(2.0 * 3.14159265358979 * 0.0457 * n));
            if (n == 200) stat_on = 1'b1;
            if (n == 966) stat_on = 1'b0;
            send(s, 1'b1, 10, 1'b0, 0);
        end
        check("sine_sample_count", stat_cnt, 766);
        check("sine_peak_within_5pct", (stat_peak >= 15200 && stat_peak <= 16800), 1);
        check("sine_mean_within_16", (stat_sum <= 16 * 766 && stat_sum >= -16 * 766), 1);

        // Reset mid-stream: next step response matches a fresh filter.
        do_reset();
        send(3048, 1'b1, 10, 1'b1, 16000);
        send(3048, 1'b1, 10, 1'b1, 15500);
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
